// File: rtl/mbist_pkg.sv
// Shared types and constants for the March C- memory BIST controller:
// FSM states, the March element table and the background word helper.
package mbist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ONLY,
    RD,
    CMP,
    WR,
    DONE
  } state_e;

  typedef struct packed {
    logic dir_down;
    logic has_read;
    logic read_bg;
    logic has_write;
    logic write_bg;
  } march_elem_t;

  localparam int NUM_ELEM = 6;
  localparam int ELEM_W   = $clog2(NUM_ELEM);

  // March C-: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) up(r0)
  localparam march_elem_t MARCH_TABLE [NUM_ELEM] = '{
    '{dir_down: 1'b0, has_read: 1'b0, read_bg: 1'b0, has_write: 1'b1, write_bg: 1'b0},
    '{dir_down: 1'b0, has_read: 1'b1, read_bg: 1'b0, has_write: 1'b1, write_bg: 1'b1},
    '{dir_down: 1'b0, has_read: 1'b1, read_bg: 1'b1, has_write: 1'b1, write_bg: 1'b0},
    '{dir_down: 1'b1, has_read: 1'b1, read_bg: 1'b0, has_write: 1'b1, write_bg: 1'b1},
    '{dir_down: 1'b1, has_read: 1'b1, read_bg: 1'b1, has_write: 1'b1, write_bg: 1'b0},
    '{dir_down: 1'b0, has_read: 1'b1, read_bg: 1'b0, has_write: 1'b0, write_bg: 1'b0}
  };

  // Widest supported data word; callers size-cast down to their DATA_W.
  localparam int BG_W = 64;

  function automatic logic [BG_W-1:0] bg(input logic b);
    return {BG_W{b}};
  endfunction

endpackage

// File: rtl/mbist_fail_log.sv
// Failing-address log: small CAM of spare-row entries with allocate-on-miss,
// a saturating unique-failure count and an overflow (not repairable) flag.
module mbist_fail_log
  import mbist_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int MAX_FAIL = 2,
  parameter int CNT_W    = $clog2(MAX_FAIL + 2)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_i,
  input  logic                       log_en_i,
  input  logic [ADDR_W-1:0]          addr_i,
  output logic [MAX_FAIL-1:0]        rep_valid_o,
  output logic [MAX_FAIL*ADDR_W-1:0] rep_addr_o,
  output logic [CNT_W-1:0]           fail_count_o,
  output logic                       overflow_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_FAIL);
  localparam logic [CNT_W-1:0] SAT_CNT = CNT_W'(MAX_FAIL + 1);

  logic [MAX_FAIL-1:0]        valid_q, valid_d;
  logic [MAX_FAIL*ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       ovf_q, ovf_d;
  logic [MAX_FAIL-1:0]        hit;
  logic [MAX_FAIL-1:0]        alloc;
  logic                       found;
  logic                       new_fail;

  for (genvar gi = 0; gi < MAX_FAIL; gi++) begin : g_entry
    assign hit[gi] = valid_q[gi] && (addr_q[gi*ADDR_W +: ADDR_W] == addr_i);
  end

  // Lowest-index free entry gets the next new failing address.
  always_comb begin
    alloc = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_FAIL; i++) begin
      if (!valid_q[i] && !found) begin
        alloc[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign new_fail = log_en_i && (hit == '0);

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr_i) begin
      valid_d = '0;
      addr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (new_fail) begin
      if (count_q < MAX_CNT) begin
        valid_d = valid_q | alloc;
        count_d = count_q + 1'b1;
        for (int i = 0; i < MAX_FAIL; i++) begin
          if (alloc[i]) addr_d[i*ADDR_W +: ADDR_W] = addr_i;
        end
      end else begin
        count_d = SAT_CNT;
        ovf_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      addr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign rep_valid_o  = valid_q;
  assign rep_addr_o   = addr_q;
  assign fail_count_o = count_q;
  assign overflow_o   = ovf_q;

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- BIST sequencer for a single-port SRAM: walks the element table,
// drives address/data/strobes, compares reads and feeds the repair log.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_FAIL = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [DATA_W-1:0]               mem_wdata,
  output logic                            mem_we,
  output logic                            mem_re,
  input  logic [DATA_W-1:0]               mem_rdata,
  output logic                            busy,
  output logic                            done,
  output logic                            fail,
  output logic                            repairable,
  output logic [$clog2(MAX_FAIL+2)-1:0]   fail_count,
  output logic [MAX_FAIL-1:0]             rep_valid,
  output logic [MAX_FAIL*ADDR_W-1:0]      rep_addr
);

  localparam int                CNT_W    = $clog2(MAX_FAIL + 2);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_e              state_q, state_d;
  logic [ELEM_W-1:0]   elem_q, elem_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                fail_q, fail_d;

  march_elem_t         cur;
  logic [ELEM_W-1:0]   elem_inc;
  logic                last_addr;
  logic                last_elem;
  logic [ADDR_W-1:0]   step_addr;
  logic                mismatch;
  logic                advance;
  logic                log_en;
  logic                log_clr;
  logic                overflow;

  assign cur       = MARCH_TABLE[elem_q];
  assign elem_inc  = elem_q + 1'b1;
  assign last_elem = (elem_q == ELEM_W'(NUM_ELEM - 1));
  assign last_addr = cur.dir_down ? (addr_q == '0) : (addr_q == ADDR_MAX);
  assign step_addr = cur.dir_down ? (addr_q - 1'b1) : (addr_q + 1'b1);
  assign mismatch  = (mem_rdata != DATA_W'(bg(cur.read_bg)));

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    addr_d  = addr_q;
    fail_d  = fail_q;
    advance = 1'b0;
    log_en  = 1'b0;
    log_clr = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          elem_d  = '0;
          addr_d  = MARCH_TABLE[0].dir_down ? ADDR_MAX : '0;
          state_d = MARCH_TABLE[0].has_read ? RD : WR_ONLY;
          fail_d  = 1'b0;
          log_clr = 1'b1;
        end
      end
      WR_ONLY: advance = 1'b1;
      RD:      state_d = CMP;
      CMP: begin
        log_en = mismatch;
        fail_d = fail_q | mismatch;
        if (cur.has_write) state_d = WR;
        else               advance = 1'b1;
      end
      WR:      advance = 1'b1;
      default: state_d = IDLE;
    endcase

    // Step within the element, or roll straight into the next one.
    if (advance) begin
      if (!last_addr) begin
        addr_d  = step_addr;
        state_d = cur.has_read ? RD : WR_ONLY;
      end else if (last_elem) begin
        state_d = DONE;
      end else begin
        elem_d  = elem_inc;
        addr_d  = MARCH_TABLE[elem_inc].dir_down ? ADDR_MAX : '0;
        state_d = MARCH_TABLE[elem_inc].has_read ? RD : WR_ONLY;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      elem_q  <= '0;
      addr_q  <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      fail_q  <= fail_d;
    end
  end

  mbist_fail_log #(
    .ADDR_W   (ADDR_W),
    .MAX_FAIL (MAX_FAIL),
    .CNT_W    (CNT_W)
  ) u_fail_log (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (log_clr),
    .log_en_i     (log_en),
    .addr_i       (addr_q),
    .rep_valid_o  (rep_valid),
    .rep_addr_o   (rep_addr),
    .fail_count_o (fail_count),
    .overflow_o   (overflow)
  );

  assign mem_addr   = addr_q;
  assign mem_we     = (state_q == WR_ONLY) || (state_q == WR);
  assign mem_re     = (state_q == RD);
  assign mem_wdata  = mem_we ? DATA_W'(bg(cur.write_bg)) : '0;
  assign busy       = state_q inside {WR_ONLY, RD, CMP, WR};
  assign done       = (state_q == DONE);
  assign fail       = fail_q;
  assign repairable = ~overflow;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: faulty behavioural RAM, strobe monitor and an
// array-level March C- model that predicts the failing-address log.
module tb_mbist_march_ctrl;

  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 8;
  localparam int MAX_FAIL = 2;
  localparam int N        = 1 << ADDR_W;
  localparam int CNT_W    = $clog2(MAX_FAIL + 2);
  localparam int RUN_CYC  = 15 * N;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       start;
  logic [ADDR_W-1:0]          mem_addr;
  logic [DATA_W-1:0]          mem_wdata;
  logic                       mem_we;
  logic                       mem_re;
  logic [DATA_W-1:0]          mem_rdata = '0;
  logic                       busy;
  logic                       done;
  logic                       fail;
  logic                       repairable;
  logic [CNT_W-1:0]           fail_count;
  logic [MAX_FAIL-1:0]        rep_valid;
  logic [MAX_FAIL*ADDR_W-1:0] rep_addr;

  always #5 clk = ~clk;

  mbist_march_ctrl #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_FAIL (MAX_FAIL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .repairable (repairable),
    .fail_count (fail_count),
    .rep_valid  (rep_valid),
    .rep_addr   (rep_addr)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Behavioural RAM with per-bit stuck-at-1 / stuck-at-0 masks on read.
  logic [DATA_W-1:0] ram [N];
  logic [DATA_W-1:0] sa1 [N];
  logic [DATA_W-1:0] sa0 [N];

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= (ram[mem_addr] | sa1[mem_addr]) & ~sa0[mem_addr];
  end

  // March C- described as plain data
  bit EL_DOWN [6] = '{0, 0, 0, 1, 1, 0};
  bit EL_RD   [6] = '{0, 1, 1, 1, 1, 1};
  bit EL_RBG  [6] = '{0, 0, 1, 0, 1, 0};
  bit EL_WR   [6] = '{1, 1, 1, 1, 1, 0};
  bit EL_WBG  [6] = '{0, 1, 0, 1, 0, 0};

  // Strobe monitor, sampled mid-cycle
  bit                mon_en = 0;
  int                busy_cyc, we_cyc, re_cyc, both_cyc, wdata_bad;
  logic [ADDR_W-1:0] rd_q [$];
  logic [ADDR_W-1:0] wr_q [$];
  logic [DATA_W-1:0] wd_q [$];

  always @(negedge clk) begin
    if (mon_en) begin
      if (busy) busy_cyc++;
      if (mem_we) begin
        we_cyc++;
        wr_q.push_back(mem_addr);
        wd_q.push_back(mem_wdata);
      end
      if (mem_re) begin
        re_cyc++;
        rd_q.push_back(mem_addr);
      end
      if (mem_we && mem_re) both_cyc++;
      if (!mem_we && mem_wdata != '0) wdata_bad++;
    end
  end

  // Reference: run the algorithm over a plain array and list unique failing
  // addresses in order of first detection.
  int exp_list [$];

  task automatic run_model();
    logic [DATA_W-1:0] m [N];
    logic [DATA_W-1:0] v;
    int a;
    bit seen;
    exp_list.delete();
    for (int i = 0; i < N; i++) m[i] = '0;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < N; k++) begin
        a = EL_DOWN[e] ? (N - 1 - k) : k;
        if (EL_RD[e]) begin
          v = (m[a] | sa1[a]) & ~sa0[a];
          if (v != {DATA_W{EL_RBG[e]}}) begin
            seen = 0;
            foreach (exp_list[j]) if (exp_list[j] == a) seen = 1;
            if (!seen) exp_list.push_back(a);
          end
        end
        if (EL_WR[e]) m[a] = {DATA_W{EL_WBG[e]}};
      end
    end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < N; i++) begin
      sa1[i] = '0;
      sa0[i] = '0;
    end
  endtask

  // Caller is at a negedge. poke_at>0 pulses start that many cycles into the run.
  task automatic do_run(input string tag, input int poke_at);
    int n, bad, wi, ri, a, u;
    logic [MAX_FAIL-1:0] exp_v;
    busy_cyc = 0; we_cyc = 0; re_cyc = 0; both_cyc = 0; wdata_bad = 0;
    rd_q.delete(); wr_q.delete(); wd_q.delete();
    run_model();
    mon_en = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, ".busy_after_start"}, busy, 1);
    check({tag, ".done_after_start"}, done, 0);
    check({tag, ".log_cleared"}, {fail, repairable, fail_count, rep_valid, rep_addr}, {1'b0, 1'b1, {CNT_W{1'b0}}, {MAX_FAIL{1'b0}}, {(MAX_FAIL*ADDR_W){1'b0}}});
    n = 1;
    while (!done && n < 1000) begin
      if (n == poke_at) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    mon_en = 0;
    check({tag, ".done"}, done, 1);
    check({tag, ".busy_cycles"}, busy_cyc, RUN_CYC);
    check({tag, ".writes"}, we_cyc, 5 * N);
    check({tag, ".reads"}, re_cyc, 5 * N);
    check({tag, ".we_re_overlap"}, both_cyc, 0);
    check({tag, ".wdata_idle"}, wdata_bad, 0);

    bad = 0; wi = 0; ri = 0;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < N; k++) begin
        a = EL_DOWN[e] ? (N - 1 - k) : k;
        if (EL_RD[e]) begin
          if (ri >= rd_q.size() || int'(rd_q[ri]) != a) bad++;
          ri++;
        end
        if (EL_WR[e]) begin
          if (wi >= wr_q.size() || int'(wr_q[wi]) != a || wd_q[wi] != {DATA_W{EL_WBG[e]}}) bad++;
          wi++;
        end
      end
    end
    check({tag, ".addr_data_order"}, bad, 0);

    u = exp_list.size();
    exp_v = (u >= 2) ? 2'b11 : ((u == 1) ? 2'b01 : 2'b00);
    check({tag, ".fail"}, fail, (u > 0));
    check({tag, ".fail_count"}, fail_count, (u > MAX_FAIL + 1) ? MAX_FAIL + 1 : u);
    check({tag, ".repairable"}, repairable, (u <= MAX_FAIL));
    check({tag, ".rep_valid"}, rep_valid, exp_v);
    if (u >= 1) check({tag, ".rep_addr0"}, rep_addr[ADDR_W-1:0], exp_list[0]);
    if (u >= 2) check({tag, ".rep_addr1"}, rep_addr[2*ADDR_W-1:ADDR_W], exp_list[1]);

    repeat (3) @(negedge clk);
    check({tag, ".done_stable"}, {done, busy, fail_count}, {1'b1, 1'b0, CNT_W'((u > MAX_FAIL + 1) ? MAX_FAIL + 1 : u)});
  endtask

  initial begin
    int n, nf, fa, fb;
    rst   = 1'b1;
    start = 1'b0;
    clear_faults();
    for (int i = 0; i < N; i++) ram[i] = '0;
    #12;
    check("reset.status", {busy, done, fail, repairable, fail_count, rep_valid}, {1'b0, 1'b0, 1'b0, 1'b1, {CNT_W{1'b0}}, {MAX_FAIL{1'b0}}});
    check("reset.strobes", {mem_we, mem_re, mem_addr, mem_wdata}, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_run("clean", 0);

    sa1[5][0] = 1'b1;
    do_run("sa5", 0);
    check("sa5.logged_once", {fail_count, rep_valid, rep_addr[ADDR_W-1:0]}, {2'd1, 2'b01, 4'd5});

    clear_faults();
    sa1[2][3] = 1'b1;
    sa1[9][1] = 1'b1;
    sa1[14][7] = 1'b1;
    do_run("sa3", 0);
    check("sa3.entries", {rep_addr, fail_count, repairable}, {4'd9, 4'd2, 2'd3, 1'b0});

    // Restart from a failing DONE, with a start poke that must be ignored.
    clear_faults();
    do_run("restart", 50);

    for (int r = 0; r < 6; r++) begin
      clear_faults();
      nf = $urandom_range(0, 4);
      for (int f = 0; f < nf; f++) begin
        fa = $urandom_range(0, N - 1);
        fb = $urandom_range(0, DATA_W - 1);
        if ($urandom_range(0, 1) == 1) sa1[fa][fb] = 1'b1;
        else                           sa0[fa][fb] = 1'b1;
      end
      do_run($sformatf("rand%0d", r), 0);
    end

    // Asynchronous reset in the middle of a run.
    clear_faults();
    sa1[3][2] = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    n = 0;
    while (!(mem_we || mem_re) && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid.strobe_before", mem_we | mem_re, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid.busy", busy, 0);
    check("rst_mid.strobes", {mem_we, mem_re}, 2'b00);
    check("rst_mid.status", {done, fail, repairable, fail_count, rep_valid}, {1'b0, 1'b0, 1'b1, {CNT_W{1'b0}}, {MAX_FAIL{1'b0}}});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_faults();
    do_run("post_rst", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
